// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU: holds one decoded instruction,
// forwards operands from MEM/WB, stalls on load-use and honours back-pressure/flush.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic            in_wb_en,
  input  logic            in_is_load,
  input  logic            flush,

  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_op,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_wb_en,
  output logic            ex_is_load,

  input  logic            mem_wb_en,
  input  logic            mem_is_load,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_val,

  input  logic            wb_wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_val
);

  logic            v_q;
  logic [3:0]      op_q;
  logic [RA_W-1:0] rs1_q;
  logic [RA_W-1:0] rs2_q;
  logic [RA_W-1:0] rd_q;
  logic [XLEN-1:0] rs1_val_q;
  logic [XLEN-1:0] rs2_val_q;
  logic [XLEN-1:0] imm_q;
  logic            use_imm_q;
  logic            wb_en_q;
  logic            is_load_q;

  logic            use1;
  logic            use2;
  logic            mem_alu_hit1;
  logic            mem_alu_hit2;
  logic            wb_hit1;
  logic            wb_hit2;
  logic            hazard;
  logic            accept;
  logic            consume;
  logic            in_wb_hit1;
  logic            in_wb_hit2;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign use1 = (rs1_q != '0);
  assign use2 = ~use_imm_q & (rs2_q != '0);

  // MEM forwards only ALU results; a load's data is not available until WB.
  assign mem_alu_hit1 = mem_wb_en & ~mem_is_load & (mem_rd == rs1_q);
  assign mem_alu_hit2 = mem_wb_en & ~mem_is_load & (mem_rd == rs2_q);
  assign wb_hit1      = wb_wb_en & (wb_rd == rs1_q);
  assign wb_hit2      = wb_wb_en & (wb_rd == rs2_q);

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rs1_fwd = rs1_val_q;
    if (rs1_q == '0)       rs1_fwd = '0;
    else if (mem_alu_hit1) rs1_fwd = mem_val;
    else if (wb_hit1)      rs1_fwd = wb_val;
  end

  always_comb begin
    rs2_fwd = rs2_val_q;
    if (rs2_q == '0)       rs2_fwd = '0;
    else if (mem_alu_hit2) rs2_fwd = mem_val;
    else if (wb_hit2)      rs2_fwd = wb_val;
  end

  assign hazard = v_q & mem_wb_en & mem_is_load &
                  ((use1 & (mem_rd == rs1_q)) | (use2 & (mem_rd == rs2_q)));

  assign ex_valid = v_q & ~hazard & ~flush;
  assign consume  = ex_valid & ex_ready;
  assign in_ready = ~v_q | consume | flush;
  assign accept   = in_valid & in_ready & ~flush;

  assign ex_a       = rs1_fwd;
  assign ex_b       = use_imm_q ? imm_q : rs2_fwd;
  assign ex_op      = op_q;
  assign ex_rd      = rd_q;
  assign ex_wb_en   = wb_en_q;
  assign ex_is_load = is_load_q;

  // A WB write landing in the same cycle as decode's read must be captured here.
  assign in_wb_hit1 = wb_wb_en & (wb_rd == in_rs1) & (in_rs1 != '0);
  assign in_wb_hit2 = wb_wb_en & (wb_rd == in_rs2) & (in_rs2 != '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      wb_en_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else if (flush) begin
      v_q <= 1'b0;
    end else if (accept) begin
      v_q       <= 1'b1;
      op_q      <= in_op;
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      rd_q      <= in_rd;
      rs1_val_q <= in_wb_hit1 ? wb_val : in_rs1_val;
      rs2_val_q <= in_wb_hit2 ? wb_val : in_rs2_val;
      imm_q     <= in_imm;
      use_imm_q <= in_use_imm;
      wb_en_q   <= in_wb_en;
      is_load_q <= in_is_load;
    end else if (consume) begin
      v_q <= 1'b0;
    end else if (v_q) begin
      // Held entry: absorb the retiring WB value so it survives the stall.
      if (use1 & wb_hit1) rs1_val_q <= wb_val;
      if (use2 & wb_hit2) rs2_val_q <= wb_val;
    end
  end

endmodule
